// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register for the 5-stage MIPS core. Captures
//                the decode bundle each cycle. It supports stall (hold),
//                flush (bubble) and a same-cycle WB->ID operand bypass, so
//                that captured or held operands never go stale.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_imm32,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src_b,
  input  logic [1:0]        id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm32,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src_b,
  output logic [1:0]        ex_reg_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_imm32;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [4:0]        r_shamt;
  logic [3:0]        r_alu_op;
  logic              r_alu_src_b;
  logic [1:0]        r_reg_dst;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  // A WB write to a nonzero register matching the operand's specifier wins
  // over the regfile value. On load it is compared against the incoming
  // specifier, and on hold against the held one.
  logic w_wb_live;
  logic w_rs_byp_load;
  logic w_rt_byp_load;
  logic w_rs_byp_hold;
  logic w_rt_byp_hold;

  assign w_wb_live     = wb_reg_write && (wb_rd != '0);
  assign w_rs_byp_load = w_wb_live && (wb_rd == id_rs);
  assign w_rt_byp_load = w_wb_live && (wb_rd == id_rt);
  assign w_rs_byp_hold = w_wb_live && (wb_rd == r_rs);
  assign w_rt_byp_hold = w_wb_live && (wb_rd == r_rt);

  // Pipeline register update with priority: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_imm32      <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_shamt      <= '0;
      r_alu_op     <= '0;
      r_alu_src_b  <= 1'b0;
      r_reg_dst    <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (stall) begin
      // Hold everything, but keep held operands fresh across WB writes.
      if (w_rs_byp_hold) r_rs_data <= wb_data;
      if (w_rt_byp_hold) r_rt_data <= wb_data;
    end else begin
      r_valid      <= id_valid;
      r_pc         <= id_pc;
      r_imm32      <= id_imm32;
      r_rs_data    <= w_rs_byp_load ? wb_data : id_rs_data;
      r_rt_data    <= w_rt_byp_load ? wb_data : id_rt_data;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_rd         <= id_rd;
      r_shamt      <= id_shamt;
      r_alu_op     <= id_alu_op;
      r_alu_src_b  <= id_alu_src_b;
      r_reg_dst    <= id_reg_dst;
      // Side-effecting controls only survive for a real instruction.
      r_reg_write  <= id_valid & id_reg_write;
      r_mem_read   <= id_valid & id_mem_read;
      r_mem_write  <= id_valid & id_mem_write;
      r_mem_to_reg <= id_valid & id_mem_to_reg;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_imm32      = r_imm32;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_shamt      = r_shamt;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src_b  = r_alu_src_b;
  assign ex_reg_dst    = r_reg_dst;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_reg
//  Description : Self-checking bench for id_ex_reg. It combines directed
//                scenarios with a randomized run against a bundle-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rsd;
    logic [DATA_W-1:0] rtd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [3:0]        alu_op;
    logic              alu_src_b;
    logic [1:0]        reg_dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } bundle_t;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  bundle_t           id;
  bundle_t           act;
  bundle_t           exp_b;

  logic              ex_valid, ex_alu_src_b;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [DATA_W-1:0] ex_pc, ex_imm32, ex_rs_data, ex_rt_data;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [4:0]        ex_shamt;
  logic [3:0]        ex_alu_op;
  logic [1:0]        ex_reg_dst;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id.valid), .id_pc(id.pc), .id_imm32(id.imm),
    .id_rs_data(id.rsd), .id_rt_data(id.rtd),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .id_shamt(id.shamt), .id_alu_op(id.alu_op),
    .id_alu_src_b(id.alu_src_b), .id_reg_dst(id.reg_dst),
    .id_reg_write(id.reg_write), .id_mem_read(id.mem_read),
    .id_mem_write(id.mem_write), .id_mem_to_reg(id.mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm32(ex_imm32),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op),
    .ex_alu_src_b(ex_alu_src_b), .ex_reg_dst(ex_reg_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  assign act = '{ex_valid, ex_pc, ex_imm32, ex_rs_data, ex_rt_data,
                 ex_rs, ex_rt, ex_rd, ex_shamt, ex_alu_op, ex_alu_src_b,
                 ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write,
                 ex_mem_to_reg};

  // Reference: what EX should hold after one edge, from the stage rules.
  function automatic bundle_t model_next(bundle_t cur, bundle_t in);
    bundle_t n;
    logic    wb_live;
    wb_live = wb_reg_write && (wb_rd != 0);
    if (rst || flush) begin
      n = '0;
    end else if (stall) begin
      n = cur;
      if (wb_live && wb_rd == cur.rs) n.rsd = wb_data;
      if (wb_live && wb_rd == cur.rt) n.rtd = wb_data;
    end else begin
      n = in;
      if (!in.valid) begin
        n.reg_write  = 1'b0;
        n.mem_read   = 1'b0;
        n.mem_write  = 1'b0;
        n.mem_to_reg = 1'b0;
      end
      if (wb_live && wb_rd == in.rs) n.rsd = wb_data;
      if (wb_live && wb_rd == in.rt) n.rtd = wb_data;
    end
    return n;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.valid      = 1'($urandom);
    b.pc         = $urandom;
    b.imm        = $urandom;
    b.rsd        = $urandom;
    b.rtd        = $urandom;
    b.rs         = REG_AW'($urandom);
    b.rt         = REG_AW'($urandom);
    b.rd         = REG_AW'($urandom);
    b.shamt      = 5'($urandom);
    b.alu_op     = 4'($urandom);
    b.alu_src_b  = 1'($urandom);
    b.reg_dst    = 2'($urandom_range(0, 2));
    b.reg_write  = 1'($urandom);
    b.mem_read   = 1'($urandom);
    b.mem_write  = 1'($urandom);
    b.mem_to_reg = 1'($urandom);
    return b;
  endfunction

  // Advance one clock. The model tracks the expected EX contents in step.
  task automatic tick();
    exp_b = model_next(exp_b, id);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    id = rand_bundle();
    id.valid = 1'b1; id.imm = 32'hFFFF8000; id.reg_write = 1'b1;
    rst = 1'b1; stall = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd3;
    exp_b = '0;
    tick();
    tests++;
    if (act !== bundle_t'('0)) begin
      fails++;
      $display("FAIL reset_edge1: got %h want 0", act);
    end
    tick();
    tests++;
    if (act !== bundle_t'('0)) begin
      fails++;
      $display("FAIL reset_edge2: got %h want 0", act);
    end
    idle_inputs();
  endtask

  task automatic test_load();
    idle_inputs();
    id = '0;
    id.valid = 1'b1; id.pc = 32'h00400004; id.imm = 32'h00007FFF;
    id.rsd = 32'h12345678; id.alu_op = 4'h2; id.reg_write = 1'b1;
    id.rs = 5'd8; id.rt = 5'd4; id.rd = 5'd2;
    tick();
    tests++;
    if (act !== id) begin
      fails++;
      $display("FAIL load_basic: got %h want %h", act, id);
    end
    tests++;
    if (act !== exp_b) begin
      fails++;
      $display("FAIL load_model: got %h want %h", act, exp_b);
    end
  endtask

  task automatic test_stall();
    bundle_t held;
    held = act;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      id = rand_bundle();
      if (c == 1) begin
        wb_reg_write = 1'b1; wb_rd = 5'd8; wb_data = 32'hCAFEBABE;
        held.rsd = 32'hCAFEBABE;
      end else begin
        wb_reg_write = 1'b0; wb_rd = 5'd8; wb_data = 32'h11111111;
      end
      tick();
      tests++;
      if (act !== held) begin
        fails++;
        $display("FAIL stall_cycle%0d: got %h want %h", c, act, held);
      end
    end
    tests++;
    if (ex_rs_data !== 32'hCAFEBABE) begin
      fails++;
      $display("FAIL stall_bypass: got %h want cafebabe", ex_rs_data);
    end
    idle_inputs();
  endtask

  task automatic test_flush_with_stall();
    idle_inputs();
    id = rand_bundle();
    id.valid = 1'b1; id.mem_write = 1'b1;
    flush = 1'b1; stall = 1'b1;
    tick();
    tests++;
    if ({ex_valid, ex_mem_write, ex_imm32} !== 34'd0) begin
      fails++;
      $display("FAIL flush_stall: got valid=%b mw=%b imm=%h want 0/0/0",
               ex_valid, ex_mem_write, ex_imm32);
    end
    tests++;
    if (act !== bundle_t'('0)) begin
      fails++;
      $display("FAIL flush_all_zero: got %h want 0", act);
    end
    idle_inputs();
  endtask

  task automatic test_bypass_load();
    idle_inputs();
    id = rand_bundle();
    id.rt = 5'd9; id.rtd = 32'h0; id.rs = 5'd1;
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000ABCD;
    tick();
    tests++;
    if (ex_rt_data !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL bypass_rt: got %h want 0000abcd", ex_rt_data);
    end
    id = rand_bundle();
    id.rt = 5'd0; id.rtd = 32'h5A5A0001; id.rs = 5'd0;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    tests++;
    if (ex_rt_data !== 32'h5A5A0001) begin
      fails++;
      $display("FAIL bypass_r0: got %h want 5a5a0001", ex_rt_data);
    end
    idle_inputs();
  endtask

  task automatic test_invalid();
    idle_inputs();
    id = rand_bundle();
    id.valid = 1'b0; id.reg_write = 1'b1; id.mem_read = 1'b1;
    id.imm = 32'hFFFF8000;
    tick();
    tests++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_imm32} !== {3'b000, 32'hFFFF8000}) begin
      fails++;
      $display("FAIL invalid_instr: got v=%b rw=%b mr=%b imm=%h want 0/0/0/ffff8000",
               ex_valid, ex_reg_write, ex_mem_read, ex_imm32);
    end
    tests++;
    if (ex_pc !== id.pc || ex_rd !== id.rd) begin
      fails++;
      $display("FAIL invalid_data: got pc=%h rd=%0d want pc=%h rd=%0d",
               ex_pc, ex_rd, id.pc, id.rd);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      id           = rand_bundle();
      rst          = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      wb_reg_write = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       wb_rd = id.rs;
        1:       wb_rd = id.rt;
        2:       wb_rd = exp_b.rs;
        default: wb_rd = REG_AW'($urandom_range(0, 2));
      endcase
      wb_data = $urandom;
      tick();
      tests++;
      if (act !== exp_b) begin
        fails++;
        if (bad < 5)
          $display("FAIL random_%0d: got %h want %h", i, act, exp_b);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    id = '0;
    exp_b = '0;
    test_reset();
    test_load();
    test_stall();
    test_flush_with_stall();
    test_load();
    test_bypass_load();
    test_invalid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
